layer_priority_mux: RTL

LAYER_PRIORITY_MUX -- requirements
Module: layer_priority_mux

---
 rtl/layer_priority_mux.sv | 105 ++++++++++
 1 files changed

// File: rtl/layer_priority_mux.sv
// Layer priority multiplexer: picks the highest-priority visible layer per pixel,
// with per-layer blinking and a per-frame collision snapshot. Two-stage pipeline.
module layer_priority_mux #(
    parameter int                   NUM_LAYERS   = 6,
    parameter int                   COLOR_W      = 8,
    parameter logic [COLOR_W-1:0]   TRANSPARENT  = 8'hFF,
    parameter int                   BLINK_FRAMES = 30
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              startOfFrame,
    input  logic                              pixelValid,
    input  logic [NUM_LAYERS-1:0]             layerRequest,
    input  logic [NUM_LAYERS*COLOR_W-1:0]     layerRGB,
    input  logic [NUM_LAYERS-1:0]             layerEnable,
    input  logic [NUM_LAYERS-1:0]             blinkMask,
    input  logic [COLOR_W-1:0]                backgroundRGB,
    output logic [COLOR_W-1:0]                RGBOut,
    output logic                              RGBValid,
    output logic [$clog2(NUM_LAYERS+1)-1:0]   winnerIdx,
    output logic [NUM_LAYERS-1:0]             collisionFlags
);

    localparam int IDX_W = $clog2(NUM_LAYERS + 1);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [NUM_LAYERS-1:0] qual;
    logic [NUM_LAYERS-1:0] hit;
    logic [IDX_W-1:0]      win_idx_d, win_idx_q;
    logic [COLOR_W-1:0]    win_rgb_d, win_rgb_q;
    logic                  valid_q;
    logic [NUM_LAYERS-1:0] col_sticky_q;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic                  blink_phase_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
            assign qual[gi] = layerRequest[gi] & layerEnable[gi]
                            & (layerRGB[gi*COLOR_W +: COLOR_W] != TRANSPARENT)
                            & ~(blinkMask[gi] & ~blink_phase_q);
            // A hit needs some other layer qualified on the same valid pixel.
            assign hit[gi] = pixelValid & qual[gi]
                           & (|(qual & ~(NUM_LAYERS'(1) << gi)));
        end
    endgenerate

    // Scan from lowest priority upward so the lowest qualified index wins.
    always_comb begin
        win_idx_d = IDX_W'(NUM_LAYERS);
        win_rgb_d = backgroundRGB;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                win_idx_d = IDX_W'(i);
                win_rgb_d = layerRGB[i*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_idx_q <= IDX_W'(NUM_LAYERS);
            win_rgb_q <= '0;
            valid_q   <= 1'b0;
            winnerIdx <= IDX_W'(NUM_LAYERS);
            RGBOut    <= '0;
            RGBValid  <= 1'b0;
        end else begin
            win_idx_q <= win_idx_d;
            win_rgb_q <= win_rgb_d;
            valid_q   <= pixelValid;
            winnerIdx <= win_idx_q;
            RGBOut    <= win_rgb_q;
            RGBValid  <= valid_q;
        end
    end

    // The startOfFrame pixel already belongs to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_sticky_q   <= '0;
            collisionFlags <= '0;
        end else if (startOfFrame) begin
            collisionFlags <= col_sticky_q;
            col_sticky_q   <= hit;
        end else begin
            col_sticky_q   <= col_sticky_q | hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (startOfFrame) begin
            if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                frame_cnt_q   <= frame_cnt_q + 1'b1;
            end
        end
    end

endmodule
